// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage RV32I pipeline: stall/flush/forwarding
// generation, memory-wait freeze with timeout, and saturating perf counters.
module hazard_ctrl_unit #(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_rs1_addrD,
  input  logic [4:0]       i_rs2_addrD,
  input  logic [4:0]       i_rs1_addrE,
  input  logic [4:0]       i_rs2_addrE,
  input  logic [4:0]       i_rd_addrE,
  input  logic [4:0]       i_rd_addrM,
  input  logic [4:0]       i_rd_addrW,
  input  logic             i_rd_wrenE,
  input  logic             i_rd_wrenM,
  input  logic             i_rd_wrenW,
  input  logic             i_lsu_rdenE,
  input  logic             i_redirectE,
  input  logic             i_lsu_reqM,
  input  logic             i_lsu_ready,
  input  logic             i_cnt_clr,
  output logic             o_stallF,
  output logic             o_stallD,
  output logic             o_stallE,
  output logic             o_stallM,
  output logic             o_flushD,
  output logic             o_flushE,
  output logic             o_flushW,
  output logic [1:0]       o_fwd_a_selE,
  output logic [1:0]       o_fwd_b_selE,
  output logic             o_lsu_timeout,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MAX_WAIT);

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  logic [1:0]        state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              tmo, freeze, lu, redirect_flush;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (i_rd_wrenM && (i_rd_addrM != 5'd0) && (i_rd_addrM == rs))
      return FWD_M;
    else if (i_rd_wrenW && (i_rd_addrW != 5'd0) && (i_rd_addrW == rs))
      return FWD_W;
    else
      return FWD_RF;
  endfunction

  assign tmo    = (state == S_WAIT) && (wcnt == WCNT_MAX) && i_lsu_reqM && !i_lsu_ready;
  assign freeze = i_lsu_reqM && !i_lsu_ready && !tmo;
  assign lu     = i_lsu_rdenE && i_rd_wrenE && (i_rd_addrE != 5'd0) &&
                  ((i_rd_addrE == i_rs1_addrD) || (i_rd_addrE == i_rs2_addrD));

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned, which would infer a latch.
    o_stallF       = 1'b0;
    o_stallD       = 1'b0;
    o_stallE       = 1'b0;
    o_stallM       = 1'b0;
    o_flushD       = 1'b0;
    o_flushE       = 1'b0;
    o_flushW       = 1'b0;
    o_fwd_a_selE   = FWD_RF;
    o_fwd_b_selE   = FWD_RF;
    o_lsu_timeout  = 1'b0;
    redirect_flush = 1'b0;
    state_nxt      = state;
    wcnt_nxt       = wcnt;

    case (state)
      S_INIT: begin
        state_nxt = S_RUN;
        wcnt_nxt  = '0;
        if (!i_rst) begin
          o_flushD = 1'b1;
          o_flushE = 1'b1;
          o_flushW = 1'b1;
        end
      end
      S_RUN, S_WAIT: begin
        if (!i_rst) begin
          o_fwd_a_selE  = fwd_sel(i_rs1_addrE);
          o_fwd_b_selE  = fwd_sel(i_rs2_addrE);
          o_lsu_timeout = tmo;
          // A redirect seen while frozen is deferred: E is held, so it
          // reappears and takes effect in the release cycle.
          if (freeze) begin
            o_stallF = 1'b1;
            o_stallD = 1'b1;
            o_stallE = 1'b1;
            o_stallM = 1'b1;
            o_flushW = 1'b1;
          end else if (i_redirectE) begin
            o_flushD       = 1'b1;
            o_flushE       = 1'b1;
            redirect_flush = 1'b1;
          end else if (lu) begin
            o_stallF = 1'b1;
            o_stallD = 1'b1;
            o_flushE = 1'b1;
          end
        end
        if (freeze) begin
          state_nxt = S_WAIT;
          wcnt_nxt  = (state == S_RUN) ? WCNT_W'(1) : wcnt + WCNT_W'(1);
        end else begin
          state_nxt = S_RUN;
          wcnt_nxt  = '0;
        end
      end
      default: begin
        state_nxt = S_INIT;
        wcnt_nxt  = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_INIT;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else if (i_cnt_clr) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (o_stallF && (o_stall_cnt != '1))
        o_stall_cnt <= o_stall_cnt + CNT_W'(1);
      if (redirect_flush && (o_flush_cnt != '1))
        o_flush_cnt <= o_flush_cnt + CNT_W'(1);
    end
  end

endmodule
